// File: rtl/pipe_stage_skid.sv
// EX->MEM pipeline register with valid/ready handshake, registered in_ready and a 2-entry skid buffer.
// Optional PIPE_STATS_EN adds saturating stall/flush counters (stat_stall, stat_flush).
module pipe_stage_skid #(
  parameter int REG_W     = 32,
  parameter int RADDR_W   = 5,
  parameter int PAYLOAD_W = 104
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [RADDR_W-1:0]   in_rd_addr,
  input  logic                 in_rd_write,
  input  logic                 in_rd_load,
  input  logic [REG_W-1:0]     in_rd_data,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RADDR_W-1:0]   out_rd_addr,
  output logic                 out_rd_write,
  output logic                 out_rd_load,
  output logic [REG_W-1:0]     out_rd_data,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 fwd_valid,
  output logic [RADDR_W-1:0]   fwd_rd_addr,
  output logic [REG_W-1:0]     fwd_rd_data,
  output logic                 load_hazard
`ifdef PIPE_STATS_EN
  ,
  output logic [31:0]          stat_stall,
  output logic [31:0]          stat_flush
`endif
);

  typedef struct packed {
    logic [RADDR_W-1:0]   rd_addr;
    logic                 rd_write;
    logic                 rd_load;
    logic [REG_W-1:0]     rd_data;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  entry_t in_entry;
  logic   acc, pop;

  assign in_entry = '{rd_addr: in_rd_addr, rd_write: in_rd_write, rd_load: in_rd_load,
                      rd_data: in_rd_data, payload: in_payload};
  assign acc = in_valid & in_ready_q;
  assign pop = out_valid & out_ready;

  // NOTE: data registers are reset (not just the state) because an empty stage must present all-zero outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default assignments up front keep this block latch-free.
    state_d    = state_q;
    in_ready_d = in_ready_q;
    head_d     = head_q;
    skid_d     = skid_q;
    if (flush) begin
      state_d    = EMPTY;
      in_ready_d = 1'b1;
      head_d     = '0;
      skid_d     = '0;
    end else begin
      unique case (state_q)
        EMPTY: if (acc) begin
          head_d  = in_entry;
          state_d = ONE;
        end
        ONE: begin
          if (acc && pop) begin
            head_d = in_entry;
          end else if (acc) begin
            skid_d     = in_entry;
            state_d    = TWO;
            in_ready_d = 1'b0;
          end else if (pop) begin
            head_d  = '0;
            state_d = EMPTY;
          end
        end
        TWO: if (pop) begin
          head_d     = skid_q;
          skid_d     = '0;
          state_d    = ONE;
          in_ready_d = 1'b1;
        end
        default: begin
          state_d    = EMPTY;
          in_ready_d = 1'b1;
          head_d     = '0;
          skid_d     = '0;
        end
      endcase
    end
  end

  // Head register is zero whenever the stage is empty, so outputs need no extra gating.
  always_comb begin
    in_ready     = in_ready_q;
    out_valid    = (state_q != EMPTY);
    out_rd_addr  = head_q.rd_addr;
    out_rd_write = head_q.rd_write;
    out_rd_load  = head_q.rd_load;
    out_rd_data  = head_q.rd_data;
    out_payload  = head_q.payload;
    fwd_valid    = out_valid & head_q.rd_write & ~head_q.rd_load & (head_q.rd_addr != '0);
    fwd_rd_addr  = head_q.rd_addr;
    fwd_rd_data  = head_q.rd_data;
    load_hazard  = out_valid & head_q.rd_load & head_q.rd_write;
  end

`ifdef PIPE_STATS_EN
  logic [31:0] stat_stall_q, stat_flush_q;

  // Counters survive flush; only rst clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_stall_q <= '0;
      stat_flush_q <= '0;
    end else begin
      if (out_valid && !out_ready && stat_stall_q != 32'hFFFF_FFFF)
        stat_stall_q <= stat_stall_q + 32'd1;
      if (flush && state_q != EMPTY && stat_flush_q != 32'hFFFF_FFFF)
        stat_flush_q <= stat_flush_q + 32'd1;
    end
  end

  assign stat_stall = stat_stall_q;
  assign stat_flush = stat_flush_q;
`endif

endmodule
